// File: rtl/div_pkg.sv
// div_pkg: shared widths and operand-entry layout for the divider operand stage
package div_pkg;
  localparam int XW_DEF = 16;
  localparam int YW_DEF = 8;
  localparam int CNT_W  = 16;
  typedef struct packed {
    logic [XW_DEF-1:0] x;
    logic [YW_DEF-1:0] y;
    logic              dz;
    logic              ovf;
  } op_entry_t;
endpackage

// File: rtl/div_flag_chk.sv
// div_flag_chk: divisor-zero and quotient-overflow detection for one operand pair
module div_flag_chk import div_pkg::*; #(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic          dz_o,
  output logic          ovf_o
);
  assign dz_o  = y_i == '0;
  assign ovf_o = x_i[XW-1:YW] >= y_i;
endmodule

// File: rtl/div_operand_stage.sv
// div_operand_stage: DEPTH-entry operand FIFO feeding an array divider; DIV_STAGE_CNT_EN adds txn/err counters
module div_operand_stage import div_pkg::*; #(
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [XW-1:0] s_dividend,
  input  logic [YW-1:0] s_divisor,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [XW-1:0] m_x,
  output logic [YW-1:0] m_y,
  output logic          m_bin,
  output logic          m_dz,
  output logic          m_ovf
`ifdef DIV_STAGE_CNT_EN
  ,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          dz;
    logic          ovf;
  } entry_t;
  entry_t        mem_q [DEPTH];
  entry_t        in_e, head;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          dz, ovf, acc, del;
  div_flag_chk #(.XW(XW), .YW(YW)) u_flag (
    .x_i  (s_dividend),
    .y_i  (s_divisor),
    .dz_o (dz),
    .ovf_o(ovf)
  );
  assign in_e    = '{x: s_dividend, y: s_divisor, dz: dz, ovf: ovf};
  assign s_ready = cnt_q != FULL;
  assign m_valid = cnt_q != '0;
  assign acc     = s_valid & s_ready;
  assign del     = m_valid & m_ready;
  assign cnt_d   = cnt_q + (AW+1)'(acc) - (AW+1)'(del);
  assign head    = m_valid ? mem_q[rd_q] : '0;
  assign m_x     = head.x;
  assign m_y     = head.y;
  assign m_dz    = head.dz;
  assign m_ovf   = head.ovf;
  assign m_bin   = 1'b0;
  // FIFO storage and pointers; reset drops every buffered pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (acc) mem_q[wr_q] <= in_e;
      if (acc) wr_q <= wr_q + 1'b1;
      if (del) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
`ifdef DIV_STAGE_CNT_EN
  logic [CNT_W-1:0] txn_q, err_q;
  assign txn_cnt = txn_q;
  assign err_cnt = err_q;
  // saturating counts of delivered pairs and of delivered pairs with a flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q <= '0;
      err_q <= '0;
    end else begin
      if (del && txn_q != '1) txn_q <= txn_q + 1'b1;
      if (del && (head.dz || head.ovf) && err_q != '1) err_q <= err_q + 1'b1;
    end
  end
`endif
endmodule
